stage_sequencer: RTL and testbench

Parametrised stage-enable generator for the CPU datapath, replacing the fixed five-step stage controller. It drives one write-enable per pipeline register plus PC, RAM and register-file strobes. It runs either sequentially (one stage per cycle) or overlapped (all stages every cycle) and honours stall, memory wait and flush requests. A retired-instruction counter is provided for bring-up and performance checks.

---
 rtl/stage_sequencer.sv | 128 ++++++++++++
 tb/tb_stage_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Stage-enable generator for the CPU datapath: sequential (one stage per cycle) or
// overlapped (all stages per cycle) operation with stall, memory wait and flush handling.
module stage_sequencer #(
   parameter  int NUM_STAGES        = 5,
   parameter  int MEM_STAGE         = 3,
   parameter  int WB_STAGE          = 4,
   parameter  int RESET_HOLD_CYCLES = 2,
   localparam int PW                = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mode,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  mem_ready,
   output logic [NUM_STAGES-1:0] stage_wren,
   output logic                  pc_wren,
   output logic                  ram_wren,
   output logic                  reg_wren,
   output logic                  stage_reset,
   output logic [PW-1:0]         active_stage,
   output logic                  cur_mode,
   output logic [31:0]           retire_count
);

   localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
   localparam logic [PW-1:0] LAST_P    = PW'(NUM_STAGES - 1);
   localparam logic [PW-1:0] MEM_P     = PW'(MEM_STAGE);
   localparam logic [PW-1:0] WB_P      = PW'(WB_STAGE);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {HOLD, SEQ, PIPE, FLUSH} state_t;

   state_t          state, next_state;
   logic [PW-1:0]   p;
   logic [PW-1:0]   f;
   logic [HW-1:0]   h;
   logic            mode_q;
   logic            advance;
   logic            restart;
   logic            retire;

   always_comb begin
      advance = 1'b0;
      case (state)
         SEQ:     advance = !stall && ((p != MEM_P) || mem_ready);
         PIPE:    advance = !stall && mem_ready;
         default: advance = 1'b0;
      endcase
   end

   // A flush request or a mode change both restart the pipeline through one FLUSH cycle.
   assign restart = flush || (mode != mode_q);
   assign retire  = advance && (((state == SEQ) && (p == LAST_P)) ||
                                ((state == PIPE) && (f == LAST_P)));

   always_ff @(posedge clk) begin
      if (reset) state <= HOLD;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         HOLD:     if (h == HOLD_LAST) next_state = mode ? PIPE : SEQ;
         SEQ,
         PIPE:     if (restart) next_state = FLUSH;
         FLUSH:    if (mode != mode_q) next_state = FLUSH;
                   else                next_state = mode_q ? PIPE : SEQ;
         default:  next_state = HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h            <= '0;
         p            <= '0;
         f            <= '0;
         retire_count <= '0;
         mode_q       <= mode;
      end else begin
         case (state)
            HOLD: begin
               mode_q <= mode;
               if (h != HOLD_LAST) h <= h + HW'(1);
            end
            SEQ, PIPE: begin
               if (retire) retire_count <= retire_count + 32'd1;
               if (restart) begin
                  mode_q <= mode;
                  p      <= '0;
                  f      <= '0;
               end else if (advance) begin
                  if (state == SEQ) p <= (p == LAST_P) ? '0 : p + PW'(1);
                  else if (f != LAST_P) f <= f + PW'(1);
               end
            end
            FLUSH: mode_q <= mode;
            default: ;
         endcase
      end
   end

   assign cur_mode = mode_q;

   always_comb begin
      stage_wren   = '0;
      pc_wren      = 1'b0;
      ram_wren     = 1'b0;
      reg_wren     = 1'b0;
      stage_reset  = (state == HOLD) || (state == FLUSH);
      active_stage = (state == SEQ) ? p : '0;
      if (advance) begin
         if (state == SEQ) begin
            stage_wren = {{(NUM_STAGES-1){1'b0}}, 1'b1} << p;
            pc_wren    = (p == LAST_P);
            ram_wren   = (p == MEM_P);
            reg_wren   = (p == WB_P);
         end else begin
            stage_wren = '1;
            pc_wren    = 1'b1;
            ram_wren   = 1'b1;
            reg_wren   = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_stage_sequencer;

   localparam int N   = 5;
   localparam int MEM = 3;
   localparam int WB  = 4;
   localparam int RH  = 2;
   localparam int PW  = 3;

   typedef struct packed {
      logic [N-1:0]  wren;
      logic          pc;
      logic          ram;
      logic          rg;
      logic          srst;
      logic [PW-1:0] act;
      logic          cm;
      logic [31:0]   ret;
   } obs_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1, mode = 1'b0, stall = 1'b0, flush = 1'b0, mem_ready = 1'b1;
   logic [N-1:0]  stage_wren;
   logic          pc_wren, ram_wren, reg_wren, stage_reset, cur_mode;
   logic [PW-1:0] active_stage;
   logic [31:0]   retire_count;

   stage_sequencer #(.NUM_STAGES(N), .MEM_STAGE(MEM), .WB_STAGE(WB), .RESET_HOLD_CYCLES(RH)) dut (
      .clk(clk), .reset(reset), .mode(mode), .stall(stall), .flush(flush), .mem_ready(mem_ready),
      .stage_wren(stage_wren), .pc_wren(pc_wren), .ram_wren(ram_wren), .reg_wren(reg_wren),
      .stage_reset(stage_reset), .active_stage(active_stage), .cur_mode(cur_mode),
      .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   obs_t q[$];
   int   tests = 0, fails = 0, cyc_no = 0;

   // Reference model: where the instruction is, how far the pipe has filled, and phase flags.
   bit          m_hold = 1'b1, m_flush = 1'b0, m_pipe = 1'b0;
   int          m_left = RH, m_ptr = 0, m_fill = 0;
   logic [31:0] m_ret = '0;

   task automatic cyc(input logic r, input logic m, input logic s, input logic fl, input logic mr);
      obs_t e;
      bit   adv;
      @(posedge clk);
      #2;
      reset = r; mode = m; stall = s; flush = fl; mem_ready = mr;
      cyc_no++;
      e = '0;
      e.cm  = m_pipe;
      e.ret = m_ret;
      adv = 1'b0;
      if (m_hold || m_flush) begin
         e.srst = 1'b1;
      end else if (!m_pipe) begin
         adv   = !s && ((m_ptr != MEM) || mr);
         e.act = PW'(m_ptr);
         if (adv) begin
            e.wren = N'(1) << m_ptr;
            e.ram  = (m_ptr == MEM);
            e.rg   = (m_ptr == WB);
            e.pc   = (m_ptr == N - 1);
         end
      end else begin
         adv = !s && mr;
         if (adv) begin
            e.wren = '1; e.pc = 1'b1; e.ram = 1'b1; e.rg = 1'b1;
         end
      end
      q.push_back(e);

      if (r) begin
         m_hold = 1'b1; m_flush = 1'b0; m_left = RH; m_ptr = 0; m_fill = 0; m_ret = '0; m_pipe = m;
      end else if (m_hold) begin
         m_pipe = m;
         m_left--;
         if (m_left == 0) m_hold = 1'b0;
      end else if (m_flush) begin
         if (m != m_pipe) m_pipe = m;
         else             m_flush = 1'b0;
      end else begin
         if (adv && !m_pipe && m_ptr == N - 1) m_ret++;
         if (adv && m_pipe && m_fill == N - 1) m_ret++;
         if (fl || m != m_pipe) begin
            m_flush = 1'b1; m_pipe = m; m_ptr = 0; m_fill = 0;
         end else if (adv) begin
            if (!m_pipe) m_ptr = (m_ptr + 1) % N;
            else if (m_fill < N - 1) m_fill++;
         end
      end
   endtask

   task automatic expect_ret(input logic [31:0] want, input string name);
      tests++;
      if (retire_count !== want) begin
         fails++;
         $display("FAIL %s retire_count got %0d want %0d", name, retire_count, want);
      end
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {stage_wren, pc_wren, ram_wren, reg_wren, stage_reset, active_stage, cur_mode, retire_count};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL cycle%0d outputs got wren=%b pc=%b ram=%b reg=%b srst=%b act=%0d cm=%b ret=%0d want wren=%b pc=%b ram=%b reg=%b srst=%b act=%0d cm=%b ret=%0d",
                        cyc_no, a.wren, a.pc, a.ram, a.rg, a.srst, a.act, a.cm, a.ret,
                        e.wren, e.pc, e.ram, e.rg, e.srst, e.act, e.cm, e.ret);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic r, m, s, fl, mr;
      // Sequential bring-up from reset
      repeat (3) cyc(1, 0, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 1);
      repeat (5) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      expect_ret(32'd1, "first_seq_retire");
      repeat (2) cyc(0, 0, 0, 0, 1);
      // Memory wait at the memory stage
      repeat (3) cyc(0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1);
      expect_ret(32'd2, "mem_wait_retire");

      // Overlapped, free running
      cyc(1, 1, 0, 0, 1);
      repeat (2) cyc(0, 1, 0, 0, 1);
      repeat (20) cyc(0, 1, 0, 0, 1);
      cyc(1, 1, 0, 0, 1);
      expect_ret(32'd16, "pipe_free_run");
      // Overlapped with a two-cycle stall
      repeat (2) cyc(0, 1, 0, 0, 1);
      for (int i = 1; i <= 20; i++) cyc(0, 1, (i == 7 || i == 8), 0, 1);
      cyc(1, 0, 0, 0, 1);
      expect_ret(32'd14, "pipe_stalled_run");

      // Flush combined with stall at stage 2
      repeat (2) cyc(0, 0, 0, 0, 1);
      repeat (2) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 1, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      expect_ret(32'd0, "flush_no_retire");
      // Mode change at stage 3
      repeat (2) cyc(0, 0, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      repeat (5) cyc(0, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 1);
      expect_ret(32'd1, "mode_change_refill");

      // Random traffic
      m = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(199) == 0);
         m  = m ^ ($urandom_range(39) == 0);
         s  = ($urandom_range(5) == 0);
         fl = ($urandom_range(29) == 0);
         mr = ($urandom_range(3) != 0);
         cyc(r, m, s, fl, mr);
      end

      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain pending got %0d want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
